// File: rtl/wide_add_seq.sv
// wide_add_seq: multi-cycle WORDS x 32-bit adder/subtractor.
//
// A single 32-bit ripple-carry adder is reused once per word, least
// significant word first. The carry between words lives in a register.
// One operation is in flight at a time. Operands enter through a
// valid/ready handshake and the result leaves through another one.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     operand handshake; a, b and sub are sampled on acceptance
//   a, b                    W-bit operands (W = 32*WORDS)
//   sub                     0: a+b, 1: a-b
//   out_valid / out_ready   result handshake
//   result                  sum or difference modulo 2^W
//   carry_out               final carry (for a subtract, 1 means no borrow)
//   overflow                two's-complement signed overflow of the W-bit op
//   busy                    high while words are being computed

// 32-bit ripple-carry adder built from one full adder per bit.
module bit32_RCA (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);
    logic [32:0] c;

    assign c[0] = cin_i;

    for (genvar gi = 0; gi < 32; gi++) begin : g_fa
        assign sum_o[gi] = a_i[gi] ^ b_i[gi] ^ c[gi];
        assign c[gi+1]   = (a_i[gi] & b_i[gi]) | (c[gi] & (a_i[gi] ^ b_i[gi]));
    end

    assign cout_o = c[32];
endmodule

module wide_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [32*WORDS-1:0]  a,
    input  logic [32*WORDS-1:0]  b,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [32*WORDS-1:0]  result,
    output logic                 carry_out,
    output logic                 overflow,
    output logic                 busy
);
    localparam int W = 32 * WORDS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           sub_q, sub_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   result_q, result_d;
    logic           carry_out_q, carry_out_d;
    logic           overflow_q, overflow_d;

    // Word slicing and one-hot word select derived from idx.
    logic [WORDS-1:0] word_sel;
    logic [31:0]      a_words [WORDS];
    logic [31:0]      b_words [WORDS];
    logic [31:0]      a_word, b_word;
    logic [31:0]      sum_w;
    logic             cout_w;
    logic             last_word;
    logic             run_q;

    assign run_q     = (state_q == RUN);
    assign last_word = (idx_q == 3'(WORDS - 1));

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
        assign word_sel[gi] = (idx_q == 3'(gi));
        assign a_words[gi]  = a_q[32*gi +: 32];
        assign b_words[gi]  = b_q[32*gi +: 32];
        // Only the word currently under the adder is rewritten.
        assign result_d[32*gi +: 32] = (run_q && word_sel[gi]) ? sum_w
                                                               : result_q[32*gi +: 32];
    end

    // AND-OR multiplexer picking the current operand words.
    always_comb begin
        a_word = '0;
        b_word = '0;
        for (int k = 0; k < WORDS; k++) begin
            a_word = a_word | ({32{word_sel[k]}} & a_words[k]);
            b_word = b_word | ({32{word_sel[k]}} & b_words[k]);
        end
    end

    // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
    bit32_RCA u_rca (
        .a_i    (a_word),
        .b_i    (b_word ^ {32{sub_q}}),
        .cin_i  (carry_q),
        .sum_o  (sum_w),
        .cout_o (cout_w)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        sub_d       = sub_q;
        carry_d     = carry_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    idx_d   = 3'd0;
                    carry_d = sub;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = cout_w;
                idx_d   = idx_q + 3'd1;
                if (last_word) begin
                    idx_d       = 3'd0;
                    state_d     = DONE;
                    carry_out_d = cout_w;
                    // Signed overflow: operand signs agree (after the
                    // subtract inversion) but the result sign differs.
                    overflow_d  = (a_q[W-1] == (b_q[W-1] ^ sub_q)) &&
                                  (sum_w[31] != a_q[W-1]);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= 3'd0;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sub_q       <= sub_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    // All handshake outputs decode from registered state only.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = run_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_wide_add_seq.sv
// Testbench for wide_add_seq (WORDS = 4). The driver pushes the expected
// response when an operand is accepted; a monitor pops and compares when a
// result handshake takes place. Expected values come from plain W-bit
// arithmetic in the bench.
module tb_wide_add_seq;
    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         sub_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         busy;

    always #5 clk = ~clk;

    wide_add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_in),
        .b         (b_in),
        .sub       (sub_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         v;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   txn_count = 0;
    bit   rand_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check1(input string name, input logic act, input logic exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: W-bit modular arithmetic; carry for subtract means a >= b;
    // overflow means the exact signed result is not representable in W bits.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input int acc);
        exp_t                e;
        logic [W:0]          u;
        logic signed [W+1:0] sx, sy, sr;
        u  = {1'b0, x} + {1'b0, y};
        sx = $signed({{2{x[W-1]}}, x});
        sy = $signed({{2{y[W-1]}}, y});
        sr = s ? (sx - sy) : (sx + sy);
        e.r   = s ? (x - y) : (x + y);
        e.c   = s ? (x >= y) : u[W];
        e.v   = (sr[W+1:W-1] != {3{sr[W-1]}});
        e.acc = acc;
        return e;
    endfunction

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v;
        int           mode;
        mode = int'($urandom_range(0, 7));
        v = '0;
        case (mode)
            0: v = '1;
            1: v = '0;
            2: v[W-1] = 1'b1;
            3: begin v = '1; v[W-1] = 1'b0; end
            default: for (int k = 0; k < WORDS; k++) v[32*k +: 32] = $urandom();
        endcase
        return v;
    endfunction

    // Present an operand and hold it until accepted; returns the number of
    // cycles spent waiting for in_ready. Called just after a rising edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic s, output int waits);
        a_in     = x;
        b_in     = y;
        sub_in   = s;
        in_valid = 1'b1;
        waits    = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(x, y, s, cyc + 1));
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            waits++;
        end
        tests_run++;
        failures++;
        $display("[TB] FAIL issue_timeout: in_ready never rose within 200 cycles");
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && in_ready) return;
        end
        tests_run++;
        failures++;
        $display("[TB] FAIL drain_timeout: %0d results still pending", sb.size());
    endtask

    // Monitor: latency on out_valid rise, value check on result handshake.
    initial begin : monitor
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                if (out_valid && !prev_valid) begin
                    if (sb.size() == 0) begin
                        tests_run++;
                        failures++;
                        $display("[TB] FAIL spurious_out_valid: got 1 expected 0 at cycle %0d", cyc);
                    end else begin
                        check_int("latency", cyc, sb[0].acc + WORDS);
                    end
                end
                if (out_valid && out_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    checkw("result", result, e.r);
                    check1("carry_out", carry_out, e.c);
                    check1("overflow", overflow, e.v);
                    txn_count++;
                    $display("[TB] txn %0d result=%h carry=%b ovf=%b", txn_count,
                             result, carry_out, overflow);
                end
                prev_valid = out_valid;
            end
        end
    end

    initial begin : driver
        int           w;
        logic [W-1:0] ones, msb, maxpos, one;
        exp_t         bp;

        ones   = '1;
        one    = W'(1);
        msb    = '0;
        msb[W-1] = 1'b1;
        maxpos = ~msb;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        sub_in    = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check1("rst_in_ready", in_ready, 1'b1);
        check1("rst_out_valid", out_valid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        checkw("rst_result", result, '0);
        check1("rst_carry_out", carry_out, 1'b0);
        check1("rst_overflow", overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full carry ripple, then observe the RUN window.
        issue(ones, one, 1'b0, w);
        @(negedge clk);
        check1("run_busy", busy, 1'b1);
        check1("run_in_ready", in_ready, 1'b0);
        check1("run_out_valid", out_valid, 1'b0);
        wait_idle();
        @(posedge clk);
        #1;

        issue(W'(5), W'(7), 1'b1, w);
        issue(maxpos, one, 1'b0, w);
        issue(msb, one, 1'b1, w);
        wait_idle();
        @(posedge clk);
        #1;

        // Backpressure: result held in DONE while a new request waits.
        out_ready = 1'b0;
        issue(ones, ones, 1'b0, w);
        bp = model(ones, ones, 1'b0, 0);
        for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
        @(posedge clk);
        #1;
        a_in     = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        b_in     = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        sub_in   = 1'b1;
        in_valid = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check1("bp_out_valid", out_valid, 1'b1);
            check1("bp_in_ready", in_ready, 1'b0);
            checkw("bp_result", result, bp.r);
            check1("bp_carry", carry_out, bp.c);
            check1("bp_ovf", overflow, bp.v);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210,
              128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b1, w);
        check_int("bp_accept_wait", w, 1);
        wait_idle();
        @(posedge clk);
        #1;

        // Reset in the middle of RUN, with idx at 2.
        issue(ones, ones, 1'b0, w);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check1("mid_rst_out_valid", out_valid, 1'b0);
        check1("mid_rst_busy", busy, 1'b0);
        checkw("mid_rst_result", result, '0);
        check1("mid_rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(W'(3), W'(4), 1'b0, w);
        wait_idle();
        @(posedge clk);
        #1;

        // Random operands with random result backpressure.
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    issue(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)), w);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_idle();
        check_int("txn_total", txn_count, 47);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
